// File: rtl/cpu_pkg.sv
// Shared constants for the CPU front end: FSM state encoding,
// instruction width and the default reset program counter.
package cpu_pkg;

  localparam int unsigned STATE_W = 2;

  localparam logic [STATE_W-1:0] S_REQ   = 2'd0;
  localparam logic [STATE_W-1:0] S_HOLD  = 2'd1;
  localparam logic [STATE_W-1:0] S_DRAIN = 2'd2;

  localparam int unsigned INSTR_W = 16;

  localparam logic [15:0] DEFAULT_RESET_PC = 16'h0000;

endpackage

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches over a req/ack memory port
// and offers the fetched word to the control unit through IR/IR_valid.
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter int unsigned     PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(DEFAULT_RESET_PC)
) (
  input  logic               CLK,
  input  logic               RST,
  output logic               mem_req,
  output logic [PC_W-1:0]    mem_addr,
  input  logic [INSTR_W-1:0] mem_rdata,
  input  logic               mem_ack,
  output logic [INSTR_W-1:0] IR,
  output logic               IR_valid,
  input  logic               CU_ready,
  input  logic               stall,
  input  logic               redirect,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic [PC_W-1:0]    PC
);

  logic [STATE_W-1:0] state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic               ir_valid_q, ir_valid_d;
  logic               mem_req_q, mem_req_d;
  logic [PC_W-1:0]    mem_addr_q, mem_addr_d;

  logic               ack_s;
  logic               consume_s;
  logic [PC_W-1:0]    pc_inc_s;
  logic [PC_W-1:0]    drain_pc_s;

  // An ack without an outstanding request is a protocol violation and is ignored.
  assign ack_s      = mem_ack & mem_req_q;
  assign consume_s  = CU_ready & ~stall;
  assign pc_inc_s   = pc_q + {{(PC_W-1){1'b0}}, 1'b1};
  assign drain_pc_s = redirect ? redirect_pc : pc_q;

  // Next-state logic; redirect outranks both ack data and consumption.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    ir_valid_d = ir_valid_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    case (state_q)
      S_REQ: begin
        if (!mem_req_q) begin
          // First cycle out of reset: nothing outstanding yet, issue now.
          mem_req_d = 1'b1;
          if (redirect) begin
            pc_d       = redirect_pc;
            mem_addr_d = redirect_pc;
          end else begin
            mem_addr_d = pc_q;
          end
        end else if (ack_s && redirect) begin
          pc_d       = redirect_pc;
          mem_addr_d = redirect_pc;
        end else if (ack_s) begin
          ir_d       = mem_rdata;
          ir_valid_d = 1'b1;
          pc_d       = pc_inc_s;
          mem_req_d  = 1'b0;
          state_d    = S_HOLD;
        end else if (redirect) begin
          // The in-flight request cannot be withdrawn; let it drain.
          pc_d    = redirect_pc;
          state_d = S_DRAIN;
        end else begin
          state_d = S_REQ;
        end
      end
      S_DRAIN: begin
        if (ack_s) begin
          pc_d       = drain_pc_s;
          mem_addr_d = drain_pc_s;
          state_d    = S_REQ;
        end else if (redirect) begin
          pc_d = redirect_pc;
        end else begin
          state_d = S_DRAIN;
        end
      end
      S_HOLD: begin
        if (redirect) begin
          ir_valid_d = 1'b0;
          pc_d       = redirect_pc;
          mem_req_d  = 1'b1;
          mem_addr_d = redirect_pc;
          state_d    = S_REQ;
        end else if (consume_s) begin
          ir_valid_d = 1'b0;
          mem_req_d  = 1'b1;
          mem_addr_d = pc_q;
          state_d    = S_REQ;
        end else begin
          state_d = S_HOLD;
        end
      end
      default: begin
        ir_valid_d = 1'b0;
        mem_req_d  = 1'b0;
        mem_addr_d = pc_q;
        state_d    = S_REQ;
      end
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= S_REQ;
      pc_q       <= RESET_PC;
      ir_q       <= {INSTR_W{1'b0}};
      ir_valid_q <= 1'b0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      ir_valid_q <= ir_valid_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
    end
  end

  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;
  assign IR       = ir_q;
  assign IR_valid = ir_valid_q;
  assign PC       = pc_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus a
// randomized run, all compared against a transaction-level fetch model.
module tb_instr_fetch_unit;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic [15:0] mem_rdata = 16'h0000;
  logic        mem_ack = 1'b0;
  logic [15:0] IR;
  logic        IR_valid;
  logic        CU_ready = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic [15:0] PC;

  int n_checks = 0;
  int n_fail   = 0;
  int n_viol   = 0;

  // Reference model: an outstanding request (m_req/m_addr), whether its data
  // is already doomed (m_squash), the presented instruction and the PC.
  logic        m_req, m_squash, m_valid;
  logic [15:0] m_addr, m_ir, m_pc;

  instr_fetch_unit #(.PC_W(16), .RESET_PC(16'h0000)) dut (
    .CLK(CLK), .RST(RST), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .IR(IR), .IR_valid(IR_valid),
    .CU_ready(CU_ready), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .PC(PC)
  );

  always #5 CLK = ~CLK;

  // Protocol monitor: an ack with no request is counted as a violation.
  always @(posedge CLK) begin
    if (!RST && mem_ack && !mem_req) n_viol++;
  end

  task automatic model_reset();
    m_req = 1'b0; m_squash = 1'b0; m_valid = 1'b0;
    m_addr = 16'h0000; m_ir = 16'h0000; m_pc = 16'h0000;
  endtask

  task automatic model_step(input logic ack, input logic [15:0] rdata,
                            input logic rdy, input logic stl,
                            input logic rd, input logic [15:0] rpc);
    if (m_req && ack) begin
      if (m_squash || rd) begin
        if (rd) m_pc = rpc;
        m_addr = m_pc;
        m_squash = 1'b0;
      end else begin
        m_ir = rdata;
        m_valid = 1'b1;
        m_pc = 16'((int'(m_pc) + 1) % 65536);
        m_req = 1'b0;
      end
    end else if (m_req) begin
      if (rd) begin
        m_pc = rpc;
        m_squash = 1'b1;
      end
    end else if (m_valid) begin
      if (rd) begin
        m_valid = 1'b0; m_pc = rpc; m_req = 1'b1; m_addr = rpc;
      end else if (rdy && !stl) begin
        m_valid = 1'b0; m_req = 1'b1; m_addr = m_pc;
      end
    end else begin
      if (rd) m_pc = rpc;
      m_req = 1'b1;
      m_addr = m_pc;
    end
  endtask

  task automatic step(input logic ack, input logic [15:0] rdata,
                      input logic rdy, input logic stl,
                      input logic rd, input logic [15:0] rpc);
    @(negedge CLK);
    mem_ack = ack; mem_rdata = rdata; CU_ready = rdy; stall = stl;
    redirect = rd; redirect_pc = rpc;
    model_step(ack, rdata, rdy, stl, rd, rpc);
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    redirect = 1'b1; redirect_pc = 16'h1234;
    repeat (2) @(posedge CLK);
    #1;
    n_checks++;
    if ({mem_req, mem_addr, IR_valid, IR, PC} !== {1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000}) begin
      n_fail++;
      $display("FAIL reset_values: got %h expected %h",
               {mem_req, mem_addr, IR_valid, IR, PC}, {1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000});
    end
    @(negedge CLK);
    redirect = 1'b0; redirect_pc = 16'h0000;
    RST = 1'b0;
    model_reset();
  endtask

  task automatic test_zero_wait();
    logic [15:0] words [2];
    words[0] = 16'h0901; words[1] = 16'h1201;
    step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000);
    n_checks++;
    if ({mem_req, mem_addr} !== {1'b1, 16'h0000}) begin
      n_fail++;
      $display("FAIL first_req: got %h expected %h", {mem_req, mem_addr}, {1'b1, 16'h0000});
    end
    for (int i = 0; i < 2; i++) begin
      step(1'b1, words[i], 1'b1, 1'b0, 1'b0, 16'h0000);
      n_checks++;
      if ({IR_valid, IR, PC} !== {1'b1, words[i], 16'(i + 1)}) begin
        n_fail++;
        $display("FAIL zero_wait_load%0d: got %h expected %h", i, {IR_valid, IR, PC}, {1'b1, words[i], 16'(i + 1)});
      end
      step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000);
      n_checks++;
      if ({mem_req, mem_addr, IR_valid} !== {1'b1, 16'(i + 1), 1'b0}) begin
        n_fail++;
        $display("FAIL zero_wait_next_req%0d: got %h expected %h", i, {mem_req, mem_addr, IR_valid}, {1'b1, 16'(i + 1), 1'b0});
      end
    end
  endtask

  task automatic test_wait_states();
    for (int i = 0; i < 11; i++) begin
      if (i < 3)       step(1'b0, 16'hDEAD, 1'b0, 1'b0, 1'b0, 16'h0000);
      else if (i == 3) step(1'b1, 16'hA5C3, 1'b0, 1'b0, 1'b0, 16'h0000);
      else if (i < 8)  step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000);
      else if (i < 10) step(1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0000);
      else             step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000);
      n_checks++;
      if ({mem_req, mem_addr, IR_valid, IR, PC} !== {m_req, m_addr, m_valid, m_ir, m_pc}) begin
        n_fail++;
        $display("FAIL wait_states_cyc%0d: got %h expected %h", i,
                 {mem_req, mem_addr, IR_valid, IR, PC}, {m_req, m_addr, m_valid, m_ir, m_pc});
      end
    end
    n_checks++;
    if ({IR, mem_addr} !== {16'hA5C3, 16'h0003}) begin
      n_fail++;
      $display("FAIL wait_states_final: got %h expected %h", {IR, mem_addr}, {16'hA5C3, 16'h0003});
    end
  endtask

  task automatic test_redirect_drain();
    step(1'b1, 16'h1111, 1'b0, 1'b0, 1'b1, 16'h0005);
    step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000);
    step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0040);
    step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000);
    n_checks++;
    if ({mem_req, mem_addr, IR_valid, PC} !== {1'b1, 16'h0005, 1'b0, 16'h0040}) begin
      n_fail++;
      $display("FAIL drain_hold_addr: got %h expected %h", {mem_req, mem_addr, IR_valid, PC}, {1'b1, 16'h0005, 1'b0, 16'h0040});
    end
    step(1'b1, 16'hBAD0, 1'b1, 1'b0, 1'b0, 16'h0000);
    n_checks++;
    if ({mem_req, mem_addr, IR_valid} !== {1'b1, 16'h0040, 1'b0}) begin
      n_fail++;
      $display("FAIL drain_discard: got %h expected %h", {mem_req, mem_addr, IR_valid}, {1'b1, 16'h0040, 1'b0});
    end
  endtask

  task automatic test_redirect_ack();
    step(1'b1, 16'hBAD1, 1'b1, 1'b0, 1'b1, 16'h0100);
    n_checks++;
    if ({mem_req, mem_addr, IR_valid, PC} !== {1'b1, 16'h0100, 1'b0, 16'h0100}) begin
      n_fail++;
      $display("FAIL redirect_ack: got %h expected %h", {mem_req, mem_addr, IR_valid, PC}, {1'b1, 16'h0100, 1'b0, 16'h0100});
    end
    step(1'b1, 16'h7E57, 1'b0, 1'b0, 1'b0, 16'h0000);
    n_checks++;
    if ({IR_valid, IR, PC} !== {1'b1, 16'h7E57, 16'h0101}) begin
      n_fail++;
      $display("FAIL redirect_ack_fetch: got %h expected %h", {IR_valid, IR, PC}, {1'b1, 16'h7E57, 16'h0101});
    end
  endtask

  task automatic test_redirect_hold();
    step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h0200);
    n_checks++;
    if ({mem_req, mem_addr, IR_valid, PC} !== {1'b1, 16'h0200, 1'b0, 16'h0200}) begin
      n_fail++;
      $display("FAIL redirect_hold: got %h expected %h", {mem_req, mem_addr, IR_valid, PC}, {1'b1, 16'h0200, 1'b0, 16'h0200});
    end
    step(1'b1, 16'h4242, 1'b0, 1'b0, 1'b0, 16'h0000);
    n_checks++;
    if ({IR_valid, IR, PC} !== {1'b1, 16'h4242, 16'h0201}) begin
      n_fail++;
      $display("FAIL redirect_hold_fetch: got %h expected %h", {IR_valid, IR, PC}, {1'b1, 16'h4242, 16'h0201});
    end
  endtask

  task automatic test_wrap();
    step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'hFFFF);
    step(1'b1, 16'hC0DE, 1'b0, 1'b0, 1'b0, 16'h0000);
    n_checks++;
    if ({IR_valid, IR, PC} !== {1'b1, 16'hC0DE, 16'h0000}) begin
      n_fail++;
      $display("FAIL pc_wrap: got %h expected %h", {IR_valid, IR, PC}, {1'b1, 16'hC0DE, 16'h0000});
    end
    step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000);
    n_checks++;
    if ({mem_req, mem_addr} !== {1'b1, 16'h0000}) begin
      n_fail++;
      $display("FAIL wrap_next_addr: got %h expected %h", {mem_req, mem_addr}, {1'b1, 16'h0000});
    end
  endtask

  task automatic test_ack_violation();
    int viol_before;
    step(1'b1, 16'h3333, 1'b0, 1'b0, 1'b0, 16'h0000);
    viol_before = n_viol;
    step(1'b1, 16'h9999, 1'b0, 1'b0, 1'b0, 16'h0000);
    n_checks++;
    if ({mem_req, mem_addr, IR_valid, IR, PC} !== {m_req, m_addr, m_valid, m_ir, m_pc}) begin
      n_fail++;
      $display("FAIL ack_violation_ignored: got %h expected %h",
               {mem_req, mem_addr, IR_valid, IR, PC}, {m_req, m_addr, m_valid, m_ir, m_pc});
    end
    n_checks++;
    if (n_viol !== viol_before + 1) begin
      n_fail++;
      $display("FAIL ack_violation_flag: got %0d expected %0d", n_viol, viol_before + 1);
    end
  endtask

  task automatic test_reset_drain();
    step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000);
    step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0777);
    #2;
    RST = 1'b1;
    #1;
    n_checks++;
    if ({mem_req, mem_addr, IR_valid, IR, PC} !== {1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000}) begin
      n_fail++;
      $display("FAIL async_reset: got %h expected %h",
               {mem_req, mem_addr, IR_valid, IR, PC}, {1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000});
    end
    @(negedge CLK);
    mem_ack = 1'b0; redirect = 1'b1; redirect_pc = 16'h0999;
    @(negedge CLK);
    redirect = 1'b0;
    RST = 1'b0;
    model_reset();
    step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000);
    n_checks++;
    if ({mem_req, mem_addr, PC} !== {1'b1, 16'h0000, 16'h0000}) begin
      n_fail++;
      $display("FAIL restart_after_reset: got %h expected %h", {mem_req, mem_addr, PC}, {1'b1, 16'h0000, 16'h0000});
    end
  endtask

  task automatic test_random();
    logic ack, rdy, stl, rd;
    logic [15:0] rpc, data;
    for (int i = 0; i < 400; i++) begin
      ack  = m_req && ($urandom_range(0, 2) == 0);
      rdy  = ($urandom_range(0, 2) != 0);
      stl  = ($urandom_range(0, 3) == 0);
      rd   = ($urandom_range(0, 7) == 0);
      rpc  = ($urandom_range(0, 5) == 0) ? 16'hFFFF : 16'($urandom);
      data = 16'($urandom);
      step(ack, data, rdy, stl, rd, rpc);
      n_checks++;
      if ({mem_req, mem_addr, IR_valid, IR, PC} !== {m_req, m_addr, m_valid, m_ir, m_pc}) begin
        n_fail++;
        $display("FAIL random_cyc%0d: got %h expected %h", i,
                 {mem_req, mem_addr, IR_valid, IR, PC}, {m_req, m_addr, m_valid, m_ir, m_pc});
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_redirect_drain();
    test_redirect_ack();
    test_redirect_hold();
    test_wrap();
    test_ack_violation();
    test_reset_drain();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetches 16-bit instructions from instruction memory over a req/ack handshake.
- Holds the result in IR and presents it to the control unit (ControlUnit_v IR input) with a valid/ready handshake.
- Owns the program counter; accepts a redirect (branch/jump/call/ret target) from the datapath.
- Sits between instruction memory and the control unit; it is the producer end of the IR interface that the control unit decodes.

Parameters:
- PC_W, 16, program counter / instruction address width.
- RESET_PC, 16'h0000, PC value after reset.

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  asynchronous, active-high reset.
- mem_req  output  1  instruction read request; held high until mem_ack.
- mem_addr  output  PC_W  read address; stable while mem_req is high.
- mem_rdata  input  16  instruction word; valid only in the mem_ack cycle.
- mem_ack  input  1  one-cycle pulse that completes the outstanding request.
- IR  output  16  instruction register to the control unit.
- IR_valid  output  1  IR holds a live instruction.
- CU_ready  input  1  control unit consumes IR this cycle when IR_valid is also high.
- stall  input  1  datapath hazard; blocks IR consumption.
- redirect  input  1  one-cycle request to load a new PC.
- redirect_pc  input  PC_W  redirect target.
- PC  output  PC_W  address of the next instruction to fetch.

Behaviour:
- Reset (async, RST=1) forces:
  - state=S_REQ
  - PC=RESET_PC
  - IR=16'h0000
  - IR_valid=0
  - mem_req=0
  - mem_addr=RESET_PC
- mem_req first asserts in the first cycle after RST deasserts.
- States:
  - S_REQ: mem_req=1, mem_addr=PC.
  - S_HOLD: IR valid, waiting for the consumer.
  - S_DRAIN: a request is outstanding but has been squashed by a redirect.
- S_REQ:
  - mem_ack=1, redirect=0: IR<=mem_rdata; IR_valid<=1; PC<=PC+1; go to S_HOLD.
  - mem_ack=0, redirect=1: PC<=redirect_pc; go to S_DRAIN. The request cannot be withdrawn: mem_req stays high and mem_addr holds the old address until ack.
  - mem_ack=1 and redirect=1 in the same cycle: discard mem_rdata; PC<=redirect_pc; stay in S_REQ and issue the new address next cycle.
- S_DRAIN:
  - mem_req=1 at the latched old address.
  - On mem_ack: discard data; go to S_REQ (new address presented next cycle).
  - A further redirect here overwrites PC (last one wins).
  - redirect together with mem_ack: PC takes the new target; go to S_REQ.
- S_HOLD:
  - mem_req=0.
  - Consume condition: CU_ready=1 and stall=0. On consume: IR_valid<=0; go to S_REQ.
  - When not consuming: IR and IR_valid hold their values.
  - redirect=1 (with or without consume): IR_valid<=0; PC<=redirect_pc; go to S_REQ.
- Priority: redirect beats consume, and redirect beats ack data.
- IR changes only when loaded from mem_ack. It keeps its stale value while IR_valid=0.
- Latency:
  - Minimum 2 cycles per instruction with a zero-wait memory (ack in the first req cycle): one req/ack cycle, one hold cycle.
  - Throughput is 1 instruction per 2 cycles.
- PC arithmetic: modulo 2^PC_W. 16'hFFFF+1 wraps to 16'h0000 with no flag.
- A redirect asserted while in reset is ignored.
- RST mid-transfer abandons the outstanding request. Memory must also be reset or tolerate the drop.
- mem_ack with mem_req=0 is a protocol violation:
  - It is ignored, with no state change.
  - The bench flags it with an assertion.

Decomposition:
- Shared package (cpu_pkg) holds:
  - state encoding constants S_REQ=2'd0, S_HOLD=2'd1, S_DRAIN=2'd2;
  - the instruction width constant INSTR_W=16;
  - the default RESET_PC.
- No sub-module is needed. A separate pc_reg (load/increment/wrap) is optional if the datapath reuses it.

Test Plan:
- Reset then zero-wait memory returning 16'h0901, 16'h1201, CU_ready=1:
  - IR=16'h0901 valid in cycle 2;
  - IR=16'h1201 valid in cycle 4;
  - mem_addr sequence 0,1,2;
  - PC=2 after the second load.
- Memory with 3 wait cycles and CU_ready=0 for 5 cycles:
  - mem_req and mem_addr stay stable until ack;
  - IR_valid stays high and IR stays unchanged until CU_ready=1;
  - stall=1 with CU_ready=1 also holds IR.
- Redirect to 16'h0040 in the second wait cycle of a fetch from 16'h0005:
  - mem_addr stays 16'h0005 until ack;
  - that data is discarded (IR_valid stays 0);
  - next request is at 16'h0040.
- Redirect to 16'h0100 coincident with mem_ack:
  - data discarded;
  - next mem_addr=16'h0100;
  - IR_valid=0 throughout.
- Redirect to 16'h0200 in S_HOLD together with CU_ready=1:
  - IR_valid drops next cycle;
  - next fetch is at 16'h0200;
  - PC is not incremented past the target.
- redirect_pc=16'hFFFF, then a fetch:
  - PC wraps to 16'h0000;
  - next mem_addr=16'h0000.
- RST pulse mid-S_DRAIN:
  - all outputs reach their reset values asynchronously;
  - fetching restarts at RESET_PC.
